// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Divide-by-zero quotient is all ones; replicated to the datapath width.
  localparam logic DIV_ZERO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decoder-to-sequencer handshake bundle; master is the decoder, slave the sequencer.
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, flush_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the loop: add-shift for multiply, restoring subtract-shift for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    isDiv_i,
  input  logic [2*DATA_WIDTH-1:0] work_i,
  input  logic [DATA_WIDTH-1:0]   operand_i,
  output logic [2*DATA_WIDTH-1:0] work_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   addSum;
  logic [W:0]   remShift;
  logic [W-1:0] remDiff;

  always_comb begin
    addSum   = {1'b0, work_i[2*W-1:W]} + (work_i[0] ? {1'b0, operand_i} : {(W+1){1'b0}});
    // Partial remainder is always below the divisor, so a successful subtract fits in W bits.
    remShift = work_i[2*W-1:W-1];
    remDiff  = remShift[W-1:0] - operand_i;
    if (isDiv_i) begin
      if (remShift >= {1'b0, operand_i}) begin
        work_o = {remDiff, work_i[W-2:0], 1'b1};
      end else begin
        work_o = {remShift[W-1:0], work_i[W-2:0], 1'b0};
      end
    end else begin
      work_o = {addSum, work_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer, one bit per clock with sign fix-up.
// Optional build macro MULDIV_ZERO_EARLY_OUT_EN: zero-operand fast path.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [2*W-1:0]         work_q;
  logic [W-1:0]           operand_q;
  logic [2:0]             op_q;
  logic                   negRes_q;
  logic                   busy_q;
  logic                   done_q;
  logic [W-1:0]           result_q;

  logic                   rs1Signed;
  logic                   rs2Signed;
  logic                   rs1Neg;
  logic                   rs2Neg;
  logic [W-1:0]           rs1Mag;
  logic [W-1:0]           rs2Mag;
  logic                   signedOvf;
  logic                   negRes_d;
  logic                   fastPath_d;
  logic [W-1:0]           fastResult_d;
  logic [2*W-1:0]         stepWork_d;
  logic [2*W-1:0]         product_d;
  logic [W-1:0]           quotient_d;
  logic [W-1:0]           remainder_d;
  logic [W-1:0]           fixResult_d;

  // Operand capture: magnitudes, result sign and fast-path detection on the start request.
  always_comb begin
    rs1Signed = (bus.funct3_i == F3_MULH) || (bus.funct3_i == F3_MULHSU) ||
                (bus.funct3_i == F3_DIV)  || (bus.funct3_i == F3_REM);
    rs2Signed = (bus.funct3_i == F3_MULH) || (bus.funct3_i == F3_DIV) ||
                (bus.funct3_i == F3_REM);
    rs1Neg    = rs1Signed & bus.rs1_data_i[W-1];
    rs2Neg    = rs2Signed & bus.rs2_data_i[W-1];
    rs1Mag    = rs1Neg ? -bus.rs1_data_i : bus.rs1_data_i;
    rs2Mag    = rs2Neg ? -bus.rs2_data_i : bus.rs2_data_i;
    negRes_d  = (bus.funct3_i == F3_REM) ? rs1Neg : (rs1Neg ^ rs2Neg);
    signedOvf = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
                (bus.rs1_data_i == {1'b1, {(W-1){1'b0}}}) &&
                (bus.rs2_data_i == {W{1'b1}});

    fastPath_d   = 1'b0;
    fastResult_d = '0;
    if (bus.funct3_i[2]) begin
      if (bus.rs2_data_i == '0) begin
        fastPath_d   = 1'b1;
        fastResult_d = bus.funct3_i[1] ? bus.rs1_data_i : {W{DIV_ZERO_FILL}};
      end else if (signedOvf) begin
        fastPath_d   = 1'b1;
        fastResult_d = bus.funct3_i[1] ? '0 : bus.rs1_data_i;
      end
`ifdef MULDIV_ZERO_EARLY_OUT_EN
      else if (bus.rs1_data_i == '0) begin
        fastPath_d = 1'b1;
      end
`endif
    end
`ifdef MULDIV_ZERO_EARLY_OUT_EN
    else if ((bus.rs1_data_i == '0) || (bus.rs2_data_i == '0)) begin
      fastPath_d = 1'b1;
    end
`endif
  end

  muldiv_step #(
    .DATA_WIDTH (W)
  ) uStep (
    .isDiv_i   (op_q[2]),
    .work_i    (work_q),
    .operand_i (operand_q),
    .work_o    (stepWork_d)
  );

  // Sign fix-up and half selection once the loop has finished.
  always_comb begin
    product_d   = negRes_q ? -work_q : work_q;
    quotient_d  = negRes_q ? -work_q[W-1:0] : work_q[W-1:0];
    remainder_d = negRes_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
    case (op_q)
      F3_MUL:                        fixResult_d = product_d[W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fixResult_d = product_d[2*W-1:W];
      F3_DIV, F3_DIVU:               fixResult_d = quotient_d;
      default:                       fixResult_d = remainder_d;
    endcase
  end

  // Main FSM; flush beats every other request and never produces a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      operand_q <= '0;
      op_q      <= '0;
      negRes_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start_i) begin
              op_q      <= bus.funct3_i;
              negRes_q  <= negRes_d;
              operand_q <= bus.funct3_i[2] ? rs2Mag : rs1Mag;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              if (fastPath_d) begin
                work_q  <= {{W{1'b0}}, fastResult_d};
                state_q <= DONE;
              end else begin
                work_q  <= {{W{1'b0}}, (bus.funct3_i[2] ? rs1Mag : rs2Mag)};
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            work_q <= stepWork_d;
            if (cnt_q == LAST_ITER) begin
              cnt_q   <= '0;
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          FIX: begin
            work_q  <= {{W{1'b0}}, fixResult_d};
            state_q <= DONE;
          end
          DONE: begin
            result_q <= work_q[W-1:0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer; honours MULDIV_ZERO_EARLY_OUT_EN when defined.
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] expQ[$];
  int          latQ[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built from plain 64-bit and 32-bit SystemVerilog arithmetic.
  function automatic logic [31:0] modelOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] sa32, sb32, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa32 = a;
    sb32 = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa32 / sb32;
        return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa32 % sb32;
        return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int modelLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    fast = (f3[2] && b == 32'd0) ||
           ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_ZERO_EARLY_OUT_EN
    if (!f3[2] && (a == 32'd0 || b == 32'd0)) fast = 1'b1;
    if (f3[2] && a == 32'd0 && b != 32'd0) fast = 1'b1;
`endif
    return fast ? 1 : 34;
  endfunction

  // Drives one request, then waits (bounded) for done_o and reports what it saw.
  task automatic issueOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output logic [31:0] res, output int lat,
                         output int busyCycles, output bit gotDone);
    expQ.push_back(exp);
    latQ.push_back(modelLatency(f3, a, b));
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.funct3_i = f3;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.funct3_i = 3'($urandom());
    bus.rs1_data_i = $urandom();
    bus.rs2_data_i = $urandom();
    lat = 0;
    busyCycles = 0;
    gotDone = 1'b0;
    res = '0;
    while (!gotDone && lat < 100) begin
      if (bus.busy_o) busyCycles++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done_o) begin
        gotDone = 1'b1;
        res = bus.result_o;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b result=%h required 0 0 00000000",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b required 0", bus.busy_o);
    end
  endtask

  task automatic test_multiply();
    vec_t v[5];
    logic [31:0] res, exp;
    int lat, bc, expLat;
    bit ok;
    v[0] = '{3'd0, 32'd7,         32'd6,         32'd42};
    v[1] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    v[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    v[4] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    foreach (v[i]) begin
      issueOp(v[i].f3, v[i].a, v[i].b, v[i].exp, res, lat, bc, ok);
      exp = expQ.pop_front();
      expLat = latQ.pop_front();
      checks++;
      if (!ok || res !== exp) begin
        errors++;
        $display("[TB] FAIL mul_result[%0d]: got %h required %h (done seen %0d)", i, res, exp, ok);
      end
      checks++;
      if (lat != expLat || bc != expLat) begin
        errors++;
        $display("[TB] FAIL mul_latency[%0d]: latency %0d busy %0d required %0d", i, lat, bc, expLat);
      end
    end
  endtask

  task automatic test_divide();
    vec_t v[6];
    logic [31:0] res, exp;
    int lat, bc, expLat;
    bit ok;
    v[0] = '{3'd4, 32'd100,       32'd7,         32'd14};
    v[1] = '{3'd6, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE};
    v[2] = '{3'd5, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF};
    v[3] = '{3'd7, 32'd100,       32'd7,         32'd2};
    v[4] = '{3'd4, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2};
    v[5] = '{3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2};
    foreach (v[i]) begin
      issueOp(v[i].f3, v[i].a, v[i].b, v[i].exp, res, lat, bc, ok);
      exp = expQ.pop_front();
      expLat = latQ.pop_front();
      checks++;
      if (!ok || res !== exp) begin
        errors++;
        $display("[TB] FAIL div_result[%0d]: got %h required %h (done seen %0d)", i, res, exp, ok);
      end
      checks++;
      if (lat != expLat) begin
        errors++;
        $display("[TB] FAIL div_latency[%0d]: got %0d required %0d", i, lat, expLat);
      end
    end
  endtask

  task automatic test_fast_path();
    vec_t v[6];
    logic [31:0] res, exp;
    int lat, bc, expLat;
    bit ok;
    v[0] = '{3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF};
    v[1] = '{3'd7, 32'h1234_5678, 32'd0,         32'h1234_5678};
    v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    v[4] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[5] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    foreach (v[i]) begin
      issueOp(v[i].f3, v[i].a, v[i].b, v[i].exp, res, lat, bc, ok);
      exp = expQ.pop_front();
      expLat = latQ.pop_front();
      checks++;
      if (!ok || res !== exp) begin
        errors++;
        $display("[TB] FAIL fast_result[%0d]: got %h required %h (done seen %0d)", i, res, exp, ok);
      end
      checks++;
      if (lat != 1 || expLat != 1 || bc != 1) begin
        errors++;
        $display("[TB] FAIL fast_latency[%0d]: latency %0d busy %0d required 1", i, lat, bc);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res, exp;
    int lat;
    bit ok;
    expQ.push_back(32'd42);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.funct3_i = 3'd0;
    bus.rs1_data_i = 32'd7;
    bus.rs2_data_i = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 0;
    ok = 1'b0;
    res = '0;
    while (!ok && lat < 100) begin
      if (lat == 5) begin
        bus.start_i = 1'b1;
        bus.funct3_i = 3'd4;
        bus.rs1_data_i = 32'd100;
        bus.rs2_data_i = 32'd0;
      end
      if (lat == 7) bus.start_i = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done_o) begin
        ok = 1'b1;
        res = bus.result_o;
      end
    end
    exp = expQ.pop_front();
    checks++;
    if (!ok || res !== exp || lat != 34) begin
      errors++;
      $display("[TB] FAIL start_while_busy: result %h latency %0d required %h latency 34", res, lat, exp);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, exp;
    int lat, bc, expLat;
    bit ok, sawDone;
    issueOp(3'd0, 32'd3, 32'd5, 32'd15, res, lat, bc, ok);
    exp = expQ.pop_front();
    expLat = latQ.pop_front();
    checks++;
    if (!ok || res !== exp || lat != expLat) begin
      errors++;
      $display("[TB] FAIL flush_setup: result %h latency %0d required %h latency %0d", res, lat, exp, expLat);
    end
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.funct3_i = 3'd0;
    bus.rs1_data_i = 32'd1234;
    bus.rs2_data_i = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd15) begin
      errors++;
      $display("[TB] FAIL flush_abort: busy=%b done=%b result=%h required 0 0 0000000f",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    issueOp(3'd0, 32'd11, 32'd13, 32'd143, res, lat, bc, ok);
    exp = expQ.pop_front();
    expLat = latQ.pop_front();
    checks++;
    if (!ok || res !== exp || lat != expLat) begin
      errors++;
      $display("[TB] FAIL after_flush: result %h latency %0d required %h latency %0d", res, lat, exp, expLat);
    end
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.funct3_i = 3'd4;
    bus.rs1_data_i = 32'd9;
    bus.rs2_data_i = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    sawDone = bus.done_o;
    checks++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_with_start: busy=%b required 0", bus.busy_o);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done_o) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0 || bus.result_o !== 32'd143) begin
      errors++;
      $display("[TB] FAIL flush_with_start_done: done seen %0d result %h required 0 0000008f",
               sawDone, bus.result_o);
    end
  endtask

  task automatic test_zero_early();
    vec_t v[4];
    logic [31:0] res, exp;
    int lat, bc, expLat;
    bit ok;
    v[0] = '{3'd0, 32'd0, 32'd5, 32'd0};
    v[1] = '{3'd3, 32'd9, 32'd0, 32'd0};
    v[2] = '{3'd4, 32'd0, 32'd5, 32'd0};
    v[3] = '{3'd6, 32'd0, 32'd5, 32'd0};
    foreach (v[i]) begin
      issueOp(v[i].f3, v[i].a, v[i].b, v[i].exp, res, lat, bc, ok);
      exp = expQ.pop_front();
      expLat = latQ.pop_front();
      checks++;
      if (!ok || res !== exp || lat != expLat) begin
        errors++;
        $display("[TB] FAIL zero_operand[%0d]: result %h latency %0d required %h latency %0d",
                 i, res, lat, exp, expLat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [2:0] f3;
    int lat, bc, expLat;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom();
      b = (i == 3) ? 32'd0 : $urandom();
      if (i % 2 == 1) b = b >> $urandom_range(0, 28);
      issueOp(f3, a, b, modelOp(f3, a, b), res, lat, bc, ok);
      exp = expQ.pop_front();
      expLat = latQ.pop_front();
      checks++;
      if (!ok || res !== exp || lat != expLat) begin
        errors++;
        $display("[TB] FAIL random[%0d] f3=%0d a=%h b=%h: result %h latency %0d required %h latency %0d",
                 i, f3, a, b, res, lat, exp, expLat);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit sawDone;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.funct3_i = 3'd0;
    bus.rs1_data_i = 32'd99;
    bus.rs2_data_i = 32'd77;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: busy=%b done=%b result=%h required 0 0 00000000",
               bus.busy_o, bus.done_o, bus.result_o);
    end
    @(negedge clk);
    reset = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: activity after reset seen %0d required 0", sawDone);
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.funct3_i = 3'd0;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    test_reset();
    test_multiply();
    test_divide();
    test_fast_path();
    test_ignore_start();
    test_flush();
    test_zero_early();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
